mxv_frame_parser: RTL and testbench
===================================

Name: mxv_frame_parser

Overview:
Parametrised successor to the MxV byte-stream data feeder. It receives bytes from the UART receiver, parses framed commands (0xFE ... 0xEF) and sets the matrix size. It streams matrix rows into BANKS row RAMs and vector elements into the vector register, then pulses start_op to the operation block. Added over the previous generation: configurable size, bank count and data width, length and command checking, inter-byte timeout, and error reporting.

Parameters:
DW, 8, byte/element width; header, length and command fields use the low 8 bits
MAX_N, 8, maximum matrix dimension N (1..MAX_N accepted)
BANKS, 4, number of row RAMs; MAX_N must be a multiple of BANKS
AW, clog2(MAX_N*MAX_N/BANKS), RAM address width
TIMEOUT, 4096, idle cycles allowed between bytes inside a frame

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rx_data  in  DW  received byte
rx_valid  in  1  one-cycle strobe; rx_data valid this cycle
size_n  out  clog2(MAX_N+1)  current matrix dimension N
ram_we  out  BANKS  one-hot write enable, selects row RAM
ram_addr  out  AW  RAM write address
ram_data  out  DW  RAM write data
vec_we  out  1  vector register write strobe
vec_idx  out  clog2(MAX_N)  vector element index
vec_data  out  DW  vector element
start_op  out  1  one-cycle pulse: vector fully loaded, start MxV
frame_ok  out  1  one-cycle pulse: frame accepted
frame_err  out  1  one-cycle pulse: frame rejected
err_code  out  3  0 none, 1 bad length, 2 bad command, 3 bad size, 4 bad terminator, 5 timeout; held until next frame_ok or frame_err
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1): state IDLE; size_n=MAX_N; all strobes 0; ram_addr, ram_data, vec_idx, vec_data = 0; err_code=0; counters cleared. A reset in mid-frame abandons the frame with no pulses.
- Frame format: 0xFE, LEN, CMD, LEN payload bytes, 0xEF. LEN counts payload bytes only.
- States: IDLE -> LEN -> CMD -> PAYLOAD -> TERM -> IDLE. Each transition consumes one rx_valid byte.
- IDLE: only 0xFE advances. Any other byte (e.g. 0xFF fill) is ignored silently.
- CMD decode, with N = size_n:
  - 0x01 SET_SIZE: LEN must be 1.
  - 0x03 LOAD_MAT: LEN must be N*N.
  - 0x04 LOAD_VEC: LEN must be N.
  - Unknown command -> error 2. LEN mismatch -> error 1. Both errors are checked at the CMD byte.
  - LEN=0 is never valid, so PAYLOAD always holds at least one byte.
- PAYLOAD: bytes are treated as data; 0xFE and 0xEF carry no special meaning here.
  - SET_SIZE: value 0 or greater than MAX_N -> error 3. A valid value is staged and applied to size_n only on frame_ok.
  - LOAD_MAT: element k has row r = k div N, col c = k mod N. Bank = r mod BANKS; addr = (r div BANKS)*MAX_N + c. ram_we[bank]=1 for exactly one cycle.
  - LOAD_VEC: vec_idx = k, vec_we=1 for one cycle.
- Write latency: strobes and data are registered and appear the cycle after the rx_valid that carried the byte.
- Writes are committed as bytes arrive and are not rolled back on a later error. Downstream treats frame_err as "contents invalid".
- TERM: 0xEF -> frame_ok in the next cycle. For LOAD_VEC, start_op is asserted in the same cycle as frame_ok. Any other byte -> error 4.
- Error handling: frame_err pulses the cycle after the offending byte, err_code is updated, and the state returns to IDLE. The error does not consume a following 0xFE.
- Timeout: a counter clears on every rx_valid and increments while busy. When it reaches TIMEOUT, raise error 5 and return to IDLE.
- rx_valid on consecutive cycles is supported: one byte per clock, no back-pressure.

Test Plan:
- Reset, then SET_SIZE: FE 01 01 03 EF -> frame_ok once, size_n=3, err_code=0, no ram_we.
- With N=3, LOAD_MAT FE 09 03 01..09 EF, BANKS=4, MAX_N=8 -> row 0 bank0 addr 0,1,2; row 1 bank1; row 2 bank2; row 3 absent; nine ram_we pulses total; frame_ok.
- With N=3, LOAD_VEC FE 03 04 0A 0B 0C EF at one byte per clock -> vec_we at idx 0,1,2 with data 0A,0B,0C; start_op and frame_ok in the same cycle.
- FE 02 04 ... with N=3 -> frame_err, err_code=1, no vec_we. Then FE 01 01 09 EF with MAX_N=8 -> frame_err, err_code=3, size_n unchanged.
- LOAD_VEC ending in 0xEE instead of 0xEF -> err_code=4, no start_op. Stream of FF bytes in IDLE -> no activity, busy=0.
- FE 03 04 0A then silence for TIMEOUT cycles -> frame_err, err_code=5, busy=0. Separately, assert rst mid-payload -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/mxv_frame_parser_if.sv
// Byte-stream input and RAM/vector write bus of the MxV frame parser.
// The parser sits on the slave side; the byte source and the sinks sit on the master side.
interface mxv_frame_parser_if #(
    parameter int DW    = 8,
    parameter int MAX_N = 8,
    parameter int BANKS = 4,
    parameter int AW    = (MAX_N * MAX_N / BANKS > 1) ? $clog2(MAX_N * MAX_N / BANKS) : 1
);
    localparam int NW = $clog2(MAX_N + 1);
    localparam int IW = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    logic [DW-1:0]    rx_data;
    logic             rx_valid;
    logic [NW-1:0]    size_n;
    logic [BANKS-1:0] ram_we;
    logic [AW-1:0]    ram_addr;
    logic [DW-1:0]    ram_data;
    logic             vec_we;
    logic [IW-1:0]    vec_idx;
    logic [DW-1:0]    vec_data;
    logic             start_op;
    logic             frame_ok;
    logic             frame_err;
    logic [2:0]       err_code;
    logic             busy;

    modport master (
        output rx_data, rx_valid,
        input  size_n, ram_we, ram_addr, ram_data, vec_we, vec_idx, vec_data,
        input  start_op, frame_ok, frame_err, err_code, busy
    );

    modport slave (
        input  rx_data, rx_valid,
        output size_n, ram_we, ram_addr, ram_data, vec_we, vec_idx, vec_data,
        output start_op, frame_ok, frame_err, err_code, busy
    );
endinterface

// File: rtl/mxv_frame_parser.sv
// Parses 0xFE LEN CMD payload 0xEF frames from the UART byte stream and drives the
// banked matrix row RAMs, the vector register and the start pulse of the MxV block.
module mxv_frame_parser #(
    parameter int DW      = 8,
    parameter int MAX_N   = 8,
    parameter int BANKS   = 4,
    parameter int AW      = (MAX_N * MAX_N / BANKS > 1) ? $clog2(MAX_N * MAX_N / BANKS) : 1,
    parameter int TIMEOUT = 4096
) (
    input logic clk,
    input logic rst,
    mxv_frame_parser_if.slave bus
);
    localparam int NW  = $clog2(MAX_N + 1);
    localparam int IW  = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam int BKW = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int BRW = (MAX_N / BANKS > 1) ? $clog2(MAX_N / BANKS) : 1;
    localparam int TW  = $clog2(TIMEOUT + 1);

    localparam logic [7:0] SOF     = 8'hFE;
    localparam logic [7:0] EOF     = 8'hEF;
    localparam logic [7:0] CMD_SET = 8'h01;
    localparam logic [7:0] CMD_MAT = 8'h03;
    localparam logic [7:0] CMD_VEC = 8'h04;

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_CMD, S_PAYLOAD, S_TERM} state_t;

    state_t           state;
    logic [7:0]       len_r, cmd_r, cnt;
    logic [IW-1:0]    col;
    logic [BKW-1:0]   bank;
    logic [BRW-1:0]   brow;
    logic [NW-1:0]    staged_n;
    logic [TW-1:0]    tcount;

    logic [NW-1:0]    size_n;
    logic [BANKS-1:0] ram_we;
    logic [AW-1:0]    ram_addr;
    logic [DW-1:0]    ram_data;
    logic             vec_we;
    logic [IW-1:0]    vec_idx;
    logic [DW-1:0]    vec_data;
    logic             start_op, frame_ok, frame_err;
    logic [2:0]       err_code;

    logic [7:0]       byte8;
    logic [15:0]      nn;
    logic             cmd_known, len_ok, last_col, size_bad;

    assign byte8     = bus.rx_data[7:0];
    assign nn        = 16'(size_n) * 16'(size_n);
    assign cmd_known = (byte8 == CMD_SET) || (byte8 == CMD_MAT) || (byte8 == CMD_VEC);
    assign last_col  = (NW'(col) == size_n - NW'(1));
    assign size_bad  = (bus.rx_data == '0) || (bus.rx_data > DW'(MAX_N));

    // LEN is already latched when the CMD byte arrives, so both checks happen here.
    always_comb begin
        len_ok = 1'b0;
        case (byte8)
            CMD_SET: len_ok = (len_r == 8'd1);
            CMD_MAT: len_ok = (16'(len_r) == nn);
            CMD_VEC: len_ok = (len_r == 8'(size_n));
            default: len_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            len_r     <= '0;
            cmd_r     <= '0;
            cnt       <= '0;
            col       <= '0;
            bank      <= '0;
            brow      <= '0;
            staged_n  <= '0;
            tcount    <= '0;
            size_n    <= NW'(MAX_N);
            ram_we    <= '0;
            ram_addr  <= '0;
            ram_data  <= '0;
            vec_we    <= 1'b0;
            vec_idx   <= '0;
            vec_data  <= '0;
            start_op  <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 3'd0;
        end else begin
            ram_we    <= '0;
            vec_we    <= 1'b0;
            start_op  <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            if (bus.rx_valid) begin
                tcount <= '0;
                case (state)
                    S_IDLE: if (byte8 == SOF) state <= S_LEN;
                    S_LEN: begin
                        len_r <= byte8;
                        state <= S_CMD;
                    end
                    S_CMD: begin
                        cmd_r <= byte8;
                        cnt   <= '0;
                        col   <= '0;
                        bank  <= '0;
                        brow  <= '0;
                        if (!cmd_known) begin
                            frame_err <= 1'b1;
                            err_code  <= 3'd2;
                            state     <= S_IDLE;
                        end else if (!len_ok) begin
                            frame_err <= 1'b1;
                            err_code  <= 3'd1;
                            state     <= S_IDLE;
                        end else begin
                            state <= S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        cnt <= cnt + 8'd1;
                        if (cnt == len_r - 8'd1) state <= S_TERM;
                        case (cmd_r)
                            CMD_SET: begin
                                if (size_bad) begin
                                    frame_err <= 1'b1;
                                    err_code  <= 3'd3;
                                    state     <= S_IDLE;
                                end else begin
                                    staged_n <= NW'(bus.rx_data);
                                end
                            end
                            CMD_MAT: begin
                                // Rows walk across banks first; each bank holds MAX_N-wide row slots.
                                ram_we   <= BANKS'(1) << bank;
                                ram_addr <= AW'(int'(brow) * MAX_N + int'(col));
                                ram_data <= bus.rx_data;
                                if (last_col) begin
                                    col <= '0;
                                    if (int'(bank) == BANKS - 1) begin
                                        bank <= '0;
                                        brow <= brow + BRW'(1);
                                    end else begin
                                        bank <= bank + BKW'(1);
                                    end
                                end else begin
                                    col <= col + IW'(1);
                                end
                            end
                            default: begin
                                vec_we   <= 1'b1;
                                vec_idx  <= IW'(cnt);
                                vec_data <= bus.rx_data;
                            end
                        endcase
                    end
                    S_TERM: begin
                        state <= S_IDLE;
                        if (byte8 == EOF) begin
                            frame_ok <= 1'b1;
                            err_code <= 3'd0;
                            if (cmd_r == CMD_SET) size_n <= staged_n;
                            if (cmd_r == CMD_VEC) start_op <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= 3'd4;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (state != S_IDLE) begin
                if (tcount == TW'(TIMEOUT - 1)) begin
                    frame_err <= 1'b1;
                    err_code  <= 3'd5;
                    state     <= S_IDLE;
                    tcount    <= '0;
                end else begin
                    tcount <= tcount + TW'(1);
                end
            end
        end
    end

    assign bus.size_n    = size_n;
    assign bus.ram_we    = ram_we;
    assign bus.ram_addr  = ram_addr;
    assign bus.ram_data  = ram_data;
    assign bus.vec_we    = vec_we;
    assign bus.vec_idx   = vec_idx;
    assign bus.vec_data  = vec_data;
    assign bus.start_op  = start_op;
    assign bus.frame_ok  = frame_ok;
    assign bus.frame_err = frame_err;
    assign bus.err_code  = err_code;
    assign bus.busy      = (state != S_IDLE);
endmodule

// File: tb/tb_mxv_frame_parser.sv
// Self-checking bench for mxv_frame_parser: directed frames plus random frames,
// each compared against a frame-level reference model of the expected writes and outcome.
module tb_mxv_frame_parser;
    localparam int DW      = 8;
    localparam int MAX_N   = 8;
    localparam int BANKS   = 4;
    localparam int AW      = $clog2(MAX_N * MAX_N / BANKS);
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mxv_frame_parser_if #(.DW(DW), .MAX_N(MAX_N), .BANKS(BANKS), .AW(AW)) bus ();

    mxv_frame_parser #(.DW(DW), .MAX_N(MAX_N), .BANKS(BANKS), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    logic [15:0] ram_cap[$];
    logic [15:0] vec_cap[$];
    int ok_cnt, err_cnt, start_cnt, start_unsync, late_wr, bad_onehot;
    logic rx_seen = 1'b0;

    always @(posedge clk) rx_seen <= bus.rx_valid;

    // Each write must follow a cycle that carried a byte, and start_op must ride with frame_ok.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ram_we != '0) begin
                ram_cap.push_back({bus.ram_we, bus.ram_addr, bus.ram_data});
                if (!rx_seen) late_wr++;
                if ($countones(bus.ram_we) != 1) bad_onehot++;
            end
            if (bus.vec_we) begin
                vec_cap.push_back(16'({bus.vec_idx, bus.vec_data}));
                if (!rx_seen) late_wr++;
            end
            if (bus.frame_ok) ok_cnt++;
            if (bus.frame_err) err_cnt++;
            if (bus.start_op) start_cnt++;
            if (bus.start_op && !bus.frame_ok) start_unsync++;
        end
    end

    task automatic clearCapture();
        ram_cap.delete();
        vec_cap.delete();
        ok_cnt = 0; err_cnt = 0; start_cnt = 0;
        start_unsync = 0; late_wr = 0; bad_onehot = 0;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [7:0]  frame_q[$];
    logic [15:0] exp_ram[$];
    logic [15:0] exp_vec[$];
    int exp_ok, exp_err, exp_start, exp_code, consume;
    int model_n = MAX_N;

    task automatic setErr(input int code, input int used);
        exp_err  = 1;
        exp_code = code;
        consume  = used;
    endtask

    task automatic buildExpect();
        int len, cmd, n, need;
        exp_ram.delete();
        exp_vec.delete();
        exp_ok = 0; exp_err = 0; exp_start = 0;
        n   = model_n;
        len = int'(frame_q[1]);
        cmd = int'(frame_q[2]);
        if (cmd != 1 && cmd != 3 && cmd != 4) begin
            setErr(2, 3);
            return;
        end
        need = (cmd == 1) ? 1 : (cmd == 3) ? n * n : n;
        if (len != need) begin
            setErr(1, 3);
            return;
        end
        consume = 3 + len + 1;
        if (cmd == 1 && (frame_q[3] == 8'd0 || int'(frame_q[3]) > MAX_N)) begin
            setErr(3, 4);
            return;
        end
        for (int k = 0; k < len; k++) begin
            int r, c;
            r = k / n;
            c = k % n;
            if (cmd == 3)
                exp_ram.push_back({BANKS'(1 << (r % BANKS)), AW'((r / BANKS) * MAX_N + c), frame_q[3+k]});
            if (cmd == 4)
                exp_vec.push_back(16'({3'(k), frame_q[3+k]}));
        end
        if (frame_q[3+len] == 8'hEF) begin
            exp_ok   = 1;
            exp_code = 0;
            if (cmd == 4) exp_start = 1;
            if (cmd == 1) model_n = int'(frame_q[3]);
        end else begin
            setErr(4, consume);
        end
    endtask

    task automatic checkFrame();
        checkOutput("ram_count", ram_cap.size(), exp_ram.size());
        for (int i = 0; i < ram_cap.size() && i < exp_ram.size(); i++)
            checkOutput($sformatf("ram_write[%0d]", i), ram_cap[i], exp_ram[i]);
        checkOutput("vec_count", vec_cap.size(), exp_vec.size());
        for (int i = 0; i < vec_cap.size() && i < exp_vec.size(); i++)
            checkOutput($sformatf("vec_write[%0d]", i), vec_cap[i], exp_vec[i]);
        checkOutput("frame_ok", ok_cnt, exp_ok);
        checkOutput("frame_err", err_cnt, exp_err);
        checkOutput("start_op", start_cnt, exp_start);
        checkOutput("start_with_ok", start_unsync, 0);
        checkOutput("write_latency", late_wr, 0);
        checkOutput("ram_we_onehot", bad_onehot, 0);
        checkOutput("err_code", bus.err_code, exp_code);
        checkOutput("size_n", bus.size_n, model_n);
        checkOutput("busy_after", bus.busy, 0);
    endtask

    task automatic runFrame(input int gap_max);
        buildExpect();
        clearCapture();
        for (int i = 0; i < consume; i++) begin
            applyStimulus(frame_q[i]);
            if (gap_max > 0) idleCycles($urandom_range(0, gap_max));
        end
        idleCycles(3);
        checkFrame();
    endtask

    task automatic genFrame();
        int kind, n, len, cmd;
        logic [7:0] b;
        logic [7:0] odd_cmds[6];
        odd_cmds = '{8'h00, 8'h02, 8'h05, 8'h7F, 8'hFE, 8'hEF};
        kind = $urandom_range(0, 9);
        n = model_n;
        case (kind)
            0, 1, 2: begin cmd = 1; len = 1; end
            3, 4:    begin cmd = 3; len = n * n; end
            7:       begin cmd = ($urandom_range(0, 1) != 0) ? 3 : 4;
                           len = ((cmd == 3) ? n * n : n) + $urandom_range(1, 3); end
            8:       begin cmd = int'(odd_cmds[$urandom_range(0, 5)]); len = $urandom_range(1, 4); end
            default: begin cmd = 4; len = n; end
        endcase
        frame_q.delete();
        frame_q.push_back(8'hFE);
        frame_q.push_back(8'(len));
        frame_q.push_back(8'(cmd));
        for (int k = 0; k < len; k++) begin
            if (kind <= 1)      b = 8'($urandom_range(1, MAX_N));
            else if (kind == 2) b = ($urandom_range(0, 1) != 0) ? 8'd0 : 8'($urandom_range(MAX_N + 1, 255));
            else                b = 8'($urandom_range(0, 255));
            frame_q.push_back(b);
        end
        b = 8'hEF;
        if (kind == 9) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hEF) b = 8'hEE;
        end
        frame_q.push_back(b);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_size_n", bus.size_n, MAX_N);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_err_code", bus.err_code, 0);
        checkOutput("rst_ram_we", bus.ram_we, 0);
        checkOutput("rst_ram_addr", bus.ram_addr, 0);
        checkOutput("rst_vec_idx", bus.vec_idx, 0);
        checkOutput("rst_pulses", {bus.frame_ok, bus.frame_err, bus.start_op, bus.vec_we}, 0);
        rst = 1'b0;
        idleCycles(2);

        frame_q = '{8'hFE, 8'h01, 8'h01, 8'h03, 8'hEF};
        runFrame(0);
        frame_q = '{8'hFE, 8'h09, 8'h03};
        for (int k = 1; k <= 9; k++) frame_q.push_back(8'(k));
        frame_q.push_back(8'hEF);
        runFrame(1);
        frame_q = '{8'hFE, 8'h03, 8'h04, 8'h0A, 8'h0B, 8'h0C, 8'hEF};
        runFrame(0);
        frame_q = '{8'hFE, 8'h02, 8'h04, 8'h0A, 8'h0B, 8'hEF};
        runFrame(0);
        frame_q = '{8'hFE, 8'h01, 8'h01, 8'h09, 8'hEF};
        runFrame(0);
        frame_q = '{8'hFE, 8'h03, 8'h04, 8'h01, 8'h02, 8'h03, 8'hEE};
        runFrame(0);

        clearCapture();
        for (int i = 0; i < 20; i++) applyStimulus(8'hFF);
        checkOutput("fill_busy", bus.busy, 0);
        idleCycles(2);
        checkOutput("fill_activity", ram_cap.size() + vec_cap.size() + ok_cnt + err_cnt, 0);

        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 3) == 0)
                for (int i = 0; i < int'($urandom_range(1, 4)); i++) applyStimulus(8'hFF);
            genFrame();
            runFrame($urandom_range(0, 1) * 2);
        end

        frame_q = '{8'hFE, 8'h01, 8'h01, 8'h03, 8'hEF};
        runFrame(0);
        clearCapture();
        applyStimulus(8'hFE);
        applyStimulus(8'h03);
        applyStimulus(8'h04);
        applyStimulus(8'h0A);
        idleCycles(TIMEOUT - 2);
        checkOutput("timeout_early", err_cnt, 0);
        checkOutput("timeout_busy_wait", bus.busy, 1);
        idleCycles(4);
        checkOutput("timeout_err", err_cnt, 1);
        checkOutput("timeout_code", bus.err_code, 5);
        checkOutput("timeout_busy", bus.busy, 0);
        checkOutput("timeout_vec", vec_cap.size(), 1);
        checkOutput("timeout_ok", ok_cnt, 0);

        clearCapture();
        frame_q = '{8'hFE, 8'h09, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04};
        for (int i = 0; i < 7; i++) applyStimulus(frame_q[i]);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_ram_we", bus.ram_we, 0);
        checkOutput("midrst_ram_addr", bus.ram_addr, 0);
        checkOutput("midrst_ram_data", bus.ram_data, 0);
        checkOutput("midrst_busy", bus.busy, 0);
        checkOutput("midrst_size_n", bus.size_n, MAX_N);
        checkOutput("midrst_err_code", bus.err_code, 0);
        checkOutput("midrst_vec", {bus.vec_idx, bus.vec_data}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_n = MAX_N;
        exp_code = 0;
        checkOutput("midrst_pulses", ok_cnt + err_cnt, 0);
        idleCycles(2);

        frame_q = '{8'hFE, 8'h08, 8'h04};
        for (int k = 0; k < 8; k++) frame_q.push_back(8'($urandom_range(0, 255)));
        frame_q.push_back(8'hEF);
        runFrame(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
